// File: rtl/pea_pkg.sv
// Shared types for the pipelined divider: operation encoding, default depth
// and the per-operation control word that travels beside the datapath.
package pea_pkg;

   typedef enum logic [1:0] {
      DIV  = 2'd0,
      REM  = 2'd1,
      DIVU = 2'd2,
      REMU = 2'd3
   } div_op_t;

   localparam int N_DIV_STAGE_DEF = 4;

   typedef struct packed {
      div_op_t op;
      logic    abs_en;
      logic    q_neg;
      logic    r_neg;
   } div_meta_t;

   function automatic logic is_signed_op(div_op_t op);
      return (op == DIV) || (op == REM);
   endfunction

   function automatic logic is_quot_op(div_op_t op);
      return (op == DIV) || (op == DIVU);
   endfunction

endpackage

// File: rtl/s_div_pipe_unit_if.sv
// Operation request / result bundle of the pipelined divider.
interface s_div_pipe_unit_if #(
   parameter int N_BITS = 32,
   parameter int SIDE_W = 1
) ();
   import pea_pkg::*;

   logic              mage_done_i;
   logic              pea_ready_i;
   div_op_t           op_i;
   logic              abs_i;
   logic [N_BITS-1:0] a_i;
   logic [N_BITS-1:0] b_i;
   logic              ops_valid_i;
   logic [SIDE_W-1:0] side_i;

   logic              ready_o;
   logic              valid_o;
   logic [N_BITS-1:0] res_o;
   logic [N_BITS-1:0] rem_q_o;
   logic [SIDE_W-1:0] side_o;
   logic              dbz_o;
   logic              busy_o;

   modport slave (
      input  mage_done_i, pea_ready_i, op_i, abs_i, a_i, b_i, ops_valid_i, side_i,
      output ready_o, valid_o, res_o, rem_q_o, side_o, dbz_o, busy_o
   );

   modport master (
      output mage_done_i, pea_ready_i, op_i, abs_i, a_i, b_i, ops_valid_i, side_i,
      input  ready_o, valid_o, res_o, rem_q_o, side_o, dbz_o, busy_o
   );
endinterface

// File: rtl/s_div_stage.sv
// One restoring-division stage: retires N_ITER quotient bits MSB first on
// unsigned magnitudes, then registers remainder, shifting dividend/quotient and divisor.
module s_div_stage #(
   parameter int N_BITS = 32,
   parameter int N_ITER = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              adv_i,
   input  logic              flush_i,
   input  logic              valid_i,
   input  logic [N_BITS-1:0] rem_i,
   input  logic [N_BITS-1:0] dq_i,
   input  logic [N_BITS-1:0] div_i,
   output logic              valid_o,
   output logic [N_BITS-1:0] rem_o,
   output logic [N_BITS-1:0] dq_o,
   output logic [N_BITS-1:0] div_o
);

   logic [N_BITS-1:0] w_rem_step [0:N_ITER];
   logic [N_BITS-1:0] w_dq_step  [0:N_ITER];

   assign w_rem_step[0] = rem_i;
   assign w_dq_step[0]  = dq_i;

   // dq shifts the dividend out of its MSB while quotient bits enter at the LSB
   genvar gi;
   for (gi = 0; gi < N_ITER; gi++) begin : g_iter
      logic [N_BITS:0] w_trial;
      logic [N_BITS:0] w_diff;
      assign w_trial            = {w_rem_step[gi], w_dq_step[gi][N_BITS-1]};
      assign w_diff             = w_trial - {1'b0, div_i};
      assign w_rem_step[gi + 1] = w_diff[N_BITS] ? w_trial[N_BITS-1:0] : w_diff[N_BITS-1:0];
      assign w_dq_step[gi + 1]  = {w_dq_step[gi][N_BITS-2:0], ~w_diff[N_BITS]};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_o <= 1'b0;
         rem_o   <= '0;
         dq_o    <= '0;
         div_o   <= '0;
      end else if (flush_i) begin
         valid_o <= 1'b0;
      end else if (adv_i) begin
         valid_o <= valid_i;
         if (valid_i) begin
            rem_o <= w_rem_step[N_ITER];
            dq_o  <= w_dq_step[N_ITER];
            div_o <= div_i;
         end
      end
   end

endmodule

// File: rtl/s_div_pipe_unit.sv
// Pipelined signed/unsigned divider: input stage (magnitudes + signs),
// N_DIV_STAGE restoring stages, output stage (sign fix, abs, result select).
module s_div_pipe_unit
   import pea_pkg::*;
#(
   parameter int N_BITS      = 32,
   parameter int N_DIV_STAGE = N_DIV_STAGE_DEF,
   parameter int SIDE_W      = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   s_div_pipe_unit_if.slave bus
);

   localparam int N_ITER = N_BITS / N_DIV_STAGE;

   if (N_DIV_STAGE < 1 || (N_BITS % N_DIV_STAGE) != 0) begin : g_bad_param
      $error("s_div_pipe_unit: N_DIV_STAGE must be >= 1 and divide N_BITS");
   end

   logic w_adv;
   logic w_flush;
   assign w_flush      = bus.mage_done_i;
   assign w_adv        = bus.pea_ready_i && !bus.mage_done_i;
   assign bus.ready_o  = w_adv;

   // index 0 is the input stage, index k the output of divider stage k
   logic [N_DIV_STAGE:0] w_valid;
   logic [N_BITS-1:0]    w_rem  [0:N_DIV_STAGE];
   logic [N_BITS-1:0]    w_dq   [0:N_DIV_STAGE];
   logic [N_BITS-1:0]    w_div  [0:N_DIV_STAGE];
   div_meta_t            w_meta [0:N_DIV_STAGE];
   logic [SIDE_W-1:0]    w_side [0:N_DIV_STAGE];

   logic              w_a_neg, w_b_neg;
   logic [N_BITS-1:0] w_a_mag, w_b_mag;
   assign w_a_neg = is_signed_op(bus.op_i) && bus.a_i[N_BITS-1];
   assign w_b_neg = is_signed_op(bus.op_i) && bus.b_i[N_BITS-1];
   assign w_a_mag = w_a_neg ? -bus.a_i : bus.a_i;
   assign w_b_mag = w_b_neg ? -bus.b_i : bus.b_i;

   logic              r_in_valid;
   logic [N_BITS-1:0] r_in_dq, r_in_div;
   div_meta_t         r_in_meta;
   logic [SIDE_W-1:0] r_in_side;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_in_valid <= 1'b0;
         r_in_dq    <= '0;
         r_in_div   <= '0;
         r_in_meta  <= '0;
         r_in_side  <= '0;
      end else if (w_flush) begin
         r_in_valid <= 1'b0;
      end else if (w_adv) begin
         r_in_valid <= bus.ops_valid_i;
         if (bus.ops_valid_i) begin
            r_in_dq          <= w_a_mag;
            r_in_div         <= w_b_mag;
            r_in_meta.op     <= bus.op_i;
            r_in_meta.abs_en <= bus.abs_i;
            r_in_meta.q_neg  <= w_a_neg ^ w_b_neg;
            r_in_meta.r_neg  <= w_a_neg;
            r_in_side        <= bus.side_i;
         end
      end
   end

   assign w_valid[0] = r_in_valid;
   assign w_rem[0]   = '0;
   assign w_dq[0]    = r_in_dq;
   assign w_div[0]   = r_in_div;
   assign w_meta[0]  = r_in_meta;
   assign w_side[0]  = r_in_side;

   genvar gi;
   for (gi = 0; gi < N_DIV_STAGE; gi++) begin : g_stage
      div_meta_t         r_meta;
      logic [SIDE_W-1:0] r_side;

      s_div_stage #(
         .N_BITS (N_BITS),
         .N_ITER (N_ITER)
      ) u_stage (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .adv_i   (w_adv),
         .flush_i (w_flush),
         .valid_i (w_valid[gi]),
         .rem_i   (w_rem[gi]),
         .dq_i    (w_dq[gi]),
         .div_i   (w_div[gi]),
         .valid_o (w_valid[gi + 1]),
         .rem_o   (w_rem[gi + 1]),
         .dq_o    (w_dq[gi + 1]),
         .div_o   (w_div[gi + 1])
      );

      // control word and sideband shadow the datapath, loading only behind a valid slot
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            r_meta <= '0;
            r_side <= '0;
         end else if (w_adv && w_valid[gi]) begin
            r_meta <= w_meta[gi];
            r_side <= w_side[gi];
         end
      end

      assign w_meta[gi + 1] = r_meta;
      assign w_side[gi + 1] = r_side;
   end

   div_meta_t         w_last_meta;
   logic              w_dbz;
   logic [N_BITS-1:0] w_q_fix, w_r_fix, w_primary, w_other, w_res;
   assign w_last_meta = w_meta[N_DIV_STAGE];
   assign w_dbz       = (w_div[N_DIV_STAGE] == '0);
   // a zero divisor yields all-ones regardless of signs; the remainder restores to a
   assign w_q_fix     = w_dbz ? '1 :
                        (w_last_meta.q_neg ? -w_dq[N_DIV_STAGE] : w_dq[N_DIV_STAGE]);
   assign w_r_fix     = w_last_meta.r_neg ? -w_rem[N_DIV_STAGE] : w_rem[N_DIV_STAGE];
   assign w_primary   = is_quot_op(w_last_meta.op) ? w_q_fix : w_r_fix;
   assign w_other     = is_quot_op(w_last_meta.op) ? w_r_fix : w_q_fix;
   // abs reads the primary as two's complement for every op; most-negative wraps
   assign w_res       = (w_last_meta.abs_en && w_primary[N_BITS-1]) ? -w_primary : w_primary;

   logic              r_valid_out, r_dbz_out;
   logic [N_BITS-1:0] r_res_out, r_rem_q_out;
   logic [SIDE_W-1:0] r_side_out;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_valid_out <= 1'b0;
         r_dbz_out   <= 1'b0;
         r_res_out   <= '0;
         r_rem_q_out <= '0;
         r_side_out  <= '0;
      end else if (w_flush) begin
         r_valid_out <= 1'b0;
         r_res_out   <= '0;
         r_rem_q_out <= '0;
      end else if (w_adv) begin
         r_valid_out <= w_valid[N_DIV_STAGE];
         if (w_valid[N_DIV_STAGE]) begin
            r_res_out   <= w_res;
            r_rem_q_out <= w_other;
            r_side_out  <= w_side[N_DIV_STAGE];
            r_dbz_out   <= w_dbz;
         end
      end
   end

   assign bus.valid_o = r_valid_out;
   assign bus.res_o   = r_res_out;
   assign bus.rem_q_o = r_rem_q_out;
   assign bus.side_o  = r_side_out;
   assign bus.dbz_o   = r_dbz_out;
   assign bus.busy_o  = |w_valid;

endmodule

// File: tb/tb_s_div_pipe_unit.sv
// Drives five divider instances (depths 1,2,4,8,32) with one stimulus stream and
// checks every output each cycle against an arithmetic reference with a delay queue.
module tb_s_div_pipe_unit;
   import pea_pkg::*;

   localparam int NB   = 32;
   localparam int SW   = 2;
   localparam int NI   = 5;
   localparam int MAIN = 2;

   function automatic int stg(int i);
      case (i)
         0:       return 1;
         1:       return 2;
         2:       return 4;
         3:       return 8;
         default: return 32;
      endcase
   endfunction

   logic          clk = 1'b0;
   logic          rst;
   logic          flush, pea_ready, ops_valid, abs_en;
   div_op_t       op;
   logic [NB-1:0] a, b;
   logic [SW-1:0] side;

   logic          w_ready [NI];
   logic          w_valid [NI];
   logic          w_busy  [NI];
   logic          w_dbz   [NI];
   logic [NB-1:0] w_res   [NI];
   logic [NB-1:0] w_remq  [NI];
   logic [SW-1:0] w_side  [NI];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      s_div_pipe_unit_if #(.N_BITS(NB), .SIDE_W(SW)) u_if ();
      assign u_if.mage_done_i = flush;
      assign u_if.pea_ready_i = pea_ready;
      assign u_if.op_i        = op;
      assign u_if.abs_i       = abs_en;
      assign u_if.a_i         = a;
      assign u_if.b_i         = b;
      assign u_if.ops_valid_i = ops_valid;
      assign u_if.side_i      = side;

      s_div_pipe_unit #(
         .N_BITS      (NB),
         .N_DIV_STAGE (stg(gi)),
         .SIDE_W      (SW)
      ) u_dut (
         .clk_i (clk),
         .rst_i (rst),
         .bus   (u_if.slave)
      );

      assign w_ready[gi] = u_if.ready_o;
      assign w_valid[gi] = u_if.valid_o;
      assign w_busy[gi]  = u_if.busy_o;
      assign w_dbz[gi]   = u_if.dbz_o;
      assign w_res[gi]   = u_if.res_o;
      assign w_remq[gi]  = u_if.rem_q_o;
      assign w_side[gi]  = u_if.side_o;
   end

   typedef struct {
      bit            v;
      logic [NB-1:0] res;
      logic [NB-1:0] remq;
      logic [SW-1:0] side;
      bit            dbz;
   } exp_t;

   function automatic exp_t zero_exp();
      exp_t e;
      e.v = 0; e.res = '0; e.remq = '0; e.side = '0; e.dbz = 0;
      return e;
   endfunction

   // Reference: plain 64-bit arithmetic, truncating division, remainder follows dividend
   function automatic exp_t ref_op(div_op_t o, bit ab, logic [NB-1:0] x, logic [NB-1:0] y,
                                   logic [SW-1:0] s);
      exp_t          e;
      longint        sx, sy, ql, rl;
      logic [NB-1:0] q, r, prim, oth;
      if (y == 0) begin
         q = '1;
         r = x;
      end else if (o == DIV || o == REM) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
         ql = sx / sy;
         rl = sx % sy;
         q  = ql[NB-1:0];
         r  = rl[NB-1:0];
      end else begin
         q = x / y;
         r = x % y;
      end
      prim = (o == DIV || o == DIVU) ? q : r;
      oth  = (o == DIV || o == DIVU) ? r : q;
      if (ab && prim[NB-1]) prim = -prim;
      e.v = 1; e.res = prim; e.remq = oth; e.side = s; e.dbz = (y == 0);
      return e;
   endfunction

   // pipe[i][k]: operation k+1 advancing edges past acceptance; out[i]: output registers
   exp_t pipe [NI][33];
   exp_t mout [NI];

   always @(posedge clk or posedge rst) begin
      exp_t inc;
      if (rst) begin
         for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 33; k++) pipe[i][k] = zero_exp();
            mout[i] = zero_exp();
         end
      end else if (flush) begin
         for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 33; k++) pipe[i][k].v = 0;
            mout[i].v    = 0;
            mout[i].res  = '0;
            mout[i].remq = '0;
         end
      end else if (pea_ready) begin
         inc = ops_valid ? ref_op(op, abs_en, a, b, side) : zero_exp();
         for (int i = 0; i < NI; i++) begin
            if (pipe[i][stg(i)].v) mout[i] = pipe[i][stg(i)];
            else                   mout[i].v = 0;
            for (int k = stg(i); k > 0; k--) pipe[i][k] = pipe[i][k-1];
            pipe[i][0] = inc;
         end
      end
   end

   task automatic chk(string name, int inst, logic [NB-1:0] act, logic [NB-1:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s (N_DIV_STAGE=%0d) t=%0t actual=%h required=%h",
                  name, stg(inst), $time, act, exp);
      else
         n_pass++;
   endtask

   always @(negedge clk) begin
      bit eb;
      for (int i = 0; i < NI; i++) begin
         eb = 0;
         for (int k = 0; k <= stg(i); k++) eb |= pipe[i][k].v;
         chk("ready_o",  i, NB'(w_ready[i]), NB'(pea_ready && !flush));
         chk("valid_o",  i, NB'(w_valid[i]), NB'(mout[i].v));
         chk("busy_o",   i, NB'(w_busy[i]),  NB'(eb));
         chk("res_o",    i, w_res[i],        mout[i].res);
         chk("rem_q_o",  i, w_remq[i],       mout[i].remq);
         chk("side_o",   i, NB'(w_side[i]),  NB'(mout[i].side));
         chk("dbz_o",    i, NB'(w_dbz[i]),   NB'(mout[i].dbz));
      end
   end

   task automatic drive(div_op_t o, bit ab, logic [NB-1:0] x, logic [NB-1:0] y,
                        logic [SW-1:0] s);
      op = o; abs_en = ab; a = x; b = y; side = s;
   endtask

   task automatic issue(div_op_t o, bit ab, logic [NB-1:0] x, logic [NB-1:0] y,
                        logic [SW-1:0] s);
      drive(o, ab, x, y, s);
      ops_valid = 1'b1;
      @(posedge clk); #1;
      ops_valid = 1'b0;
   endtask

   task automatic adv(int k);
      repeat (k) begin
         @(posedge clk); #1;
      end
   endtask

   function automatic logic [NB-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return NB'($urandom_range(0, 20));
         4:       return -NB'($urandom_range(1, 20));
         default: return NB'($urandom);
      endcase
   endfunction

   initial begin
      rst = 1'b1; flush = 1'b0; pea_ready = 1'b1; ops_valid = 1'b0;
      drive(DIV, 1'b0, '0, '0, '0);
      adv(2);
      rst = 1'b0;
      chk("lit_reset_valid", MAIN, NB'(w_valid[MAIN]), '0);
      chk("lit_reset_busy",  MAIN, NB'(w_busy[MAIN]),  '0);
      chk("lit_reset_res",   MAIN, w_res[MAIN],        '0);

      // -7 / 2 with sideband 1
      issue(DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, 2'd1);
      adv(4);
      chk("lit_div_early_valid", MAIN, NB'(w_valid[MAIN]), '0);
      adv(1);
      chk("lit_div_valid", MAIN, NB'(w_valid[MAIN]), 32'd1);
      chk("lit_div_res",   MAIN, w_res[MAIN],        32'hFFFF_FFFD);
      chk("lit_div_remq",  MAIN, w_remq[MAIN],       32'hFFFF_FFFF);
      chk("lit_div_side",  MAIN, NB'(w_side[MAIN]),  32'd1);
      chk("lit_div_dbz",   MAIN, NB'(w_dbz[MAIN]),   '0);

      // back-to-back: REMU 100/7, REMU 9/0, DIV min/-1
      drive(REMU, 1'b0, 32'd100, 32'd7, 2'd2); ops_valid = 1'b1; adv(1);
      drive(REMU, 1'b0, 32'd9, 32'd0, 2'd3);   adv(1);
      drive(DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 2'd0); adv(1);
      ops_valid = 1'b0;
      adv(3);
      chk("lit_remu_res",  MAIN, w_res[MAIN],  32'd2);
      chk("lit_remu_remq", MAIN, w_remq[MAIN], 32'd14);
      adv(1);
      chk("lit_dbz_res",   MAIN, w_res[MAIN],      32'd9);
      chk("lit_dbz_remq",  MAIN, w_remq[MAIN],     32'hFFFF_FFFF);
      chk("lit_dbz_flag",  MAIN, NB'(w_dbz[MAIN]), 32'd1);
      adv(1);
      chk("lit_ovf_res",   MAIN, w_res[MAIN],      32'h8000_0000);
      chk("lit_ovf_remq",  MAIN, w_remq[MAIN],     '0);
      chk("lit_ovf_dbz",   MAIN, NB'(w_dbz[MAIN]), '0);

      // abs of -20/3
      issue(DIV, 1'b1, 32'hFFFF_FFEC, 32'd3, 2'd0);
      adv(5);
      chk("lit_abs_res",  MAIN, w_res[MAIN],  32'd6);
      chk("lit_abs_remq", MAIN, w_remq[MAIN], 32'hFFFF_FFFE);

      // three-cycle stall one cycle after acceptance
      issue(DIVU, 1'b0, 32'd1000, 32'd10, 2'd2);
      adv(1);
      pea_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         adv(1);
         chk("lit_stall_busy",  MAIN, NB'(w_busy[MAIN]),  32'd1);
         chk("lit_stall_valid", MAIN, NB'(w_valid[MAIN]), '0);
      end
      pea_ready = 1'b1;
      adv(3);
      chk("lit_stall_early_valid", MAIN, NB'(w_valid[MAIN]), '0);
      adv(1);
      chk("lit_stall_valid_out", MAIN, NB'(w_valid[MAIN]), 32'd1);
      chk("lit_stall_res",       MAIN, w_res[MAIN],        32'd100);
      chk("lit_stall_side",      MAIN, NB'(w_side[MAIN]),  32'd2);

      // flush with three operations in flight
      drive(DIVU, 1'b0, 32'd50, 32'd5, 2'd1); ops_valid = 1'b1; adv(1);
      drive(REM, 1'b0, 32'd51, 32'd5, 2'd2);  adv(1);
      drive(DIV, 1'b0, 32'd52, 32'd5, 2'd3);  adv(1);
      ops_valid = 1'b0; flush = 1'b1;
      adv(1);
      flush = 1'b0;
      chk("lit_flush_valid", MAIN, NB'(w_valid[MAIN]), '0);
      chk("lit_flush_busy",  MAIN, NB'(w_busy[MAIN]),  '0);
      chk("lit_flush_res",   MAIN, w_res[MAIN],        '0);
      for (int s = 0; s < 8; s++) begin
         adv(1);
         chk("lit_flush_late_valid", MAIN, NB'(w_valid[MAIN]), '0);
      end

      // asynchronous reset between edges while results are live
      drive(DIV, 1'b0, 32'd100, 32'd3, 2'd3); ops_valid = 1'b1;
      repeat (6) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("lit_arst_valid", MAIN, NB'(w_valid[MAIN]), '0);
      chk("lit_arst_busy",  MAIN, NB'(w_busy[MAIN]),  '0);
      chk("lit_arst_res",   MAIN, w_res[MAIN],        '0);
      chk("lit_arst_remq",  MAIN, w_remq[MAIN],       '0);
      chk("lit_arst_side",  MAIN, NB'(w_side[MAIN]),  '0);
      ops_valid = 1'b0;
      adv(1);
      rst = 1'b0;

      // randomized regression across all depths
      for (int c = 0; c < 4000; c++) begin
         ops_valid = ($urandom_range(0, 9) < 7);
         pea_ready = ($urandom_range(0, 9) < 8);
         flush     = ($urandom_range(0, 49) == 0);
         drive(div_op_t'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), pick(), pick(),
               SW'($urandom_range(0, 3)));
         adv(1);
      end
      ops_valid = 1'b0; pea_ready = 1'b1; flush = 1'b0;
      adv(40);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/s_div_pipe_unit.md
S_DIV_PIPE_UNIT -- requirements
Module: s_div_pipe_unit

Interface
REQ-001 SHALL have parameter N_BITS, default 32: operand/result width.
REQ-002 SHALL have parameter N_DIV_STAGE, default 4: number of iterative divider stages; N_BITS % N_DIV_STAGE == 0.
REQ-003 SHALL have parameter SIDE_W, default 1: sideband width (delay-operand sign bits) carried alongside each operation.
REQ-004 SHALL have the port clk_i, input, 1: the single clock; all state on posedge.
REQ-005 SHALL have the port rst_i, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have the port mage_done_i, input, 1: flush; empties the pipeline.
REQ-007 SHALL have the port pea_ready_i, input, 1: global advance; 0 stalls every stage.
REQ-008 SHALL have the port op_i, input, div_op_t (2b): DIV, REM, DIVU, REMU.
REQ-009 SHALL have the port abs_i, input, 1: return |primary result|.
REQ-010 SHALL have the port a_i / b_i, input, N_BITS each: dividend / divisor.
REQ-011 SHALL have the port ops_valid_i, input, 1: operands valid.
REQ-012 SHALL have the port side_i, input, SIDE_W: sideband travelling with the operation.
REQ-013 SHALL have the port ready_o, output, 1: equals pea_ready_i && !mage_done_i.
REQ-014 SHALL have the port valid_o, output, 1: res_o, rem_q_o, side_o and dbz_o are valid.
REQ-015 SHALL have the port res_o, output, N_BITS: quotient for DIV/DIVU, remainder for REM/REMU.
REQ-016 SHALL have the port rem_q_o, output, N_BITS: the other of the two results, never abs-adjusted.
REQ-017 SHALL have the port side_o, output, SIDE_W: side_i of the same operation.
REQ-018 SHALL have the port dbz_o, output, 1: divisor was zero.
REQ-019 SHALL have the port busy_o, output, 1: OR of all internal stage valid bits.

Function
REQ-020 SHALL accept an operation in every cycle where ops_valid_i && ready_o; there is no back-pressure beyond pea_ready_i.
REQ-021 SHALL deliver the result with valid_o high exactly N_DIV_STAGE+1 advancing cycles (pea_ready_i=1) after acceptance; cycles with pea_ready_i=0 do not count.
REQ-022 SHALL sustain a throughput of one operation per advancing cycle; bubbles propagate as valid=0 slots.
REQ-023 SHALL register operands in the input stage: magnitudes for signed ops, quotient sign = sign(a)^sign(b), remainder sign = sign(a).
REQ-024 SHALL make each of the N_DIV_STAGE stages retire N_BITS/N_DIV_STAGE quotient bits (restoring, MSB first); the output stage applies the sign correction and abs.
REQ-025 SHALL, for signed ops, truncate the quotient toward zero and give the remainder the sign of the dividend.
REQ-026 SHALL, when b=0, produce quotient all-ones and remainder=a, and set dbz_o=1 with that result; signed and unsigned behave the same.
REQ-027 SHALL, for signed a=most-negative and b=-1, produce quotient=a and remainder=0, with dbz_o=0.
REQ-028 SHALL, with abs_i=1, output res_o=|primary|; most-negative stays most-negative (wrap).
REQ-029 SHALL, when pea_ready_i=0, hold every stage register (data, valid, sideband, op, flags) and hold the outputs.
REQ-030 SHALL carry side_i through a valid-qualified shift chain gated by the same advance enable, so side_o aligns with res_o for any N_DIV_STAGE and under stalls.
REQ-031 SHALL, when mage_done_i=1, clear all stage valid bits and valid_o on the next edge, set res_o and rem_q_o to 0, and accept nothing; it takes priority over pea_ready_i.
REQ-032 SHALL, when acceptance and flush occur in the same cycle, drop the operation.
REQ-033 SHALL hold the output registers in the cycles where valid_o is low.

Reset
REQ-034 SHALL, with rst_i high, clear immediately and asynchronously all stage valids, valid_o, busy_o, dbz_o, res_o, rem_q_o, side_o and all data registers to 0; operations in flight mid-operation are discarded.
REQ-035 SHALL, after rst_i falls, accept an operation on the first edge with ops_valid_i && ready_o.

Structure
REQ-036 SHALL define div_op_t and the default N_DIV_STAGE in pea_pkg.
REQ-037 SHALL implement one divider stage as the sub-module s_div_stage (remainder/quotient/divisor in, N_BITS/N_DIV_STAGE iterations, registered out, advance enable); it is instantiated N_DIV_STAGE times in a generate loop.
REQ-038 SHALL check the parameter legality (N_BITS % N_DIV_STAGE == 0, N_DIV_STAGE >= 1) with an elaboration-time assertion.

Verification
REQ-039 SHALL cover this case: N_BITS=32, N_DIV_STAGE=4, DIV a=-7 b=2 side=1 -> after 5 cycles valid_o=1, res_o=-3, rem_q_o=-1, side_o=1, dbz_o=0.
REQ-040 SHALL cover this case: back-to-back REMU 100/7, 9/0, DIV 0x80000000/-1 -> res_o 2, 9 (dbz_o=1), and for the third op res_o=0x80000000 (primary quotient) with rem_q_o=0, on consecutive cycles 5,6,7.
REQ-041 SHALL cover this case: ABSDIV (DIV, abs_i=1) a=-20 b=3 -> res_o=6, rem_q_o=-2.
REQ-042 SHALL cover this case: accept op, drop pea_ready_i for 3 cycles at cycle 2 -> valid_o at cycle 8, result and side_o unchanged, and busy_o high throughout.
REQ-043 SHALL cover this case: three ops in flight, then mage_done_i pulse -> next cycle valid_o=0, busy_o=0, res_o=0, and no late valid appears.
REQ-044 SHALL cover this case: rst_i asserted mid-stream, asynchronously between edges -> outputs are 0 before the next edge; random signed/unsigned regression against a reference model for N_DIV_STAGE in {1,2,4,8,32}.
